// File: rtl/man_alu_pipe.sv
// ---------------------------------------------------------------------------
// man_alu_pipe
//   Two-stage pipelined mantissa add/subtract unit for the BFP16 adder.
//   Operands arrive aligned, with the larger magnitude first. The effective
//   operation is an add when the signs match and a subtract otherwise. The
//   result carries overflow, zero and leading-zero-count flags for the
//   downstream normaliser. A valid/ready handshake on each side lets the
//   datapath stall without losing operations. The pipeline holds up to two
//   operations.
//
// Parameters
//   SIZE_MAN   mantissa width in bits (>= 2)
//   SIZE_LZC   width of the leading-zero count (derived from SIZE_MAN)
//
// Ports
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_valid     input operation valid
//   o_ready     block can accept an input this cycle (combinational from i_ready)
//   i_sign_a    sign of the larger-magnitude operand
//   i_sign_b    sign of the smaller-magnitude operand
//   i_carry     guard/sticky borrow from alignment (effective subtract only)
//   i_man_max   larger-magnitude aligned mantissa
//   i_man_min   smaller-magnitude aligned mantissa
//   o_valid     result valid
//   i_ready     downstream accepts the result
//   o_man_alu   result mantissa
//   o_overflow  carry-out on effective add; always 0 on subtract
//   o_zero      o_man_alu == 0
//   o_lzc       leading zeros of o_man_alu; SIZE_MAN when the result is zero
// ---------------------------------------------------------------------------
module man_alu_pipe #(
   parameter  int SIZE_MAN = 8,
   localparam int SIZE_LZC = $clog2(SIZE_MAN + 1)
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_valid,
   output logic                o_ready,
   input  logic                i_sign_a,
   input  logic                i_sign_b,
   input  logic                i_carry,
   input  logic [SIZE_MAN-1:0] i_man_max,
   input  logic [SIZE_MAN-1:0] i_man_min,
   output logic                o_valid,
   input  logic                i_ready,
   output logic [SIZE_MAN-1:0] o_man_alu,
   output logic                o_overflow,
   output logic                o_zero,
   output logic [SIZE_LZC-1:0] o_lzc
);

   // Count leading zeros, MSB first; returns SIZE_MAN for an all-zero value.
   function automatic logic [SIZE_LZC-1:0] count_lz(input logic [SIZE_MAN-1:0] v);
      logic [SIZE_LZC-1:0] cnt;
      logic                found;
      cnt   = '0;
      found = 1'b0;
      for (int i = SIZE_MAN - 1; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      cnt   = cnt + SIZE_LZC'(1);
         end
      end
      return cnt;
   endfunction

   // Stage 1 registers
   logic                r_s1_valid;
   logic [SIZE_MAN-1:0] r_s1_max;
   logic [SIZE_MAN-1:0] r_s1_min;
   logic                r_s1_add;
   logic                r_s1_cin;

   // Stage 2 registers (drive the outputs directly)
   logic                r_s2_valid;
   logic [SIZE_MAN-1:0] r_s2_man;
   logic                r_s2_ovf;
   logic                r_s2_zero;
   logic [SIZE_LZC-1:0] r_s2_lzc;

   logic                w_s2_load;
   logic                w_s1_load;
   logic [SIZE_MAN:0]   w_sum;
   logic [SIZE_MAN-1:0] w_res;
   logic                w_ovf;

   assign w_s2_load = r_s1_valid & (~r_s2_valid | i_ready);
   assign o_ready   = ~r_s1_valid | w_s2_load;
   assign w_s1_load = i_valid & o_ready;

   // One (SIZE_MAN+1)-bit adder covers both operations; on subtract the
   // operand is inverted and the borrow-adjusted carry-in completes the
   // two's complement. The carry-out is meaningful only on an add.
   always_comb begin
      w_sum = {1'b0, r_s1_max}
            + (r_s1_add ? {1'b0, r_s1_min} : {1'b0, ~r_s1_min})
            + {{SIZE_MAN{1'b0}}, (~r_s1_add & r_s1_cin)};
      w_res = w_sum[SIZE_MAN-1:0];
      w_ovf = r_s1_add & w_sum[SIZE_MAN];
   end

   // ---- Stage 1: capture operands, operation and carry-in ----
   // Data may load while i_valid=0; r_s1_valid keeps it from reaching S2.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_max   <= '0;
         r_s1_min   <= '0;
         r_s1_add   <= 1'b0;
         r_s1_cin   <= 1'b0;
      end else if (o_ready) begin
         r_s1_valid <= w_s1_load;
         r_s1_max   <= i_man_max;
         r_s1_min   <= i_man_min;
         r_s1_add   <= ~(i_sign_a ^ i_sign_b);
         r_s1_cin   <= ~i_carry;
      end
   end

   // ---- Stage 2: register result and normaliser flags ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_man   <= '0;
         r_s2_ovf   <= 1'b0;
         r_s2_zero  <= 1'b0;
         r_s2_lzc   <= '0;
      end else if (w_s2_load) begin
         r_s2_valid <= 1'b1;
         r_s2_man   <= w_res;
         r_s2_ovf   <= w_ovf;
         r_s2_zero  <= (w_res == '0);
         r_s2_lzc   <= count_lz(w_res);
      end else if (i_ready) begin
         r_s2_valid <= 1'b0;
      end
   end

   assign o_valid    = r_s2_valid;
   assign o_man_alu  = r_s2_man;
   assign o_overflow = r_s2_ovf;
   assign o_zero     = r_s2_zero;
   assign o_lzc      = r_s2_lzc;

endmodule

// File: doc/man_alu_pipe.md
Name: man_alu_pipe

Overview:
Pipelined, parametrised successor to the BFP16 adder's combinational mantissa add/subtract unit. It takes aligned mantissas (larger-magnitude first), performs effective add or subtract based on operand signs, and registers the result over two stages. The result carries overflow, zero and leading-zero-count flags for the downstream normaliser. A valid/ready handshake lets the adder datapath stall without losing operations.

Parameters:
SIZE_MAN, 8, mantissa width in bits, ≥2
SIZE_LZC, $clog2(SIZE_MAN+1), width of leading-zero count (derived, not overridden)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  input operation valid
o_ready  out  1  block can accept input this cycle
i_sign_a  in  1  sign of larger-magnitude operand
i_sign_b  in  1  sign of smaller-magnitude operand
i_carry  in  1  guard/sticky borrow from alignment; used only on effective subtract
i_man_max  in  SIZE_MAN  larger-magnitude aligned mantissa
i_man_min  in  SIZE_MAN  smaller-magnitude aligned mantissa
o_valid  out  1  result valid
i_ready  in  1  downstream accepts result
o_man_alu  out  SIZE_MAN  result mantissa
o_overflow  out  1  carry-out on effective add; always 0 on subtract
o_zero  out  1  o_man_alu == 0
o_lzc  out  SIZE_LZC  leading zeros of o_man_alu (MSB first); SIZE_MAN when zero

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst_n is asynchronous and active-low.
- Reset state: all stage valids 0, o_valid=0, o_man_alu=0, o_overflow=0, o_zero=0, o_lzc=0. An asserted reset discards in-flight operations. Deassertion takes effect synchronously on the next edge. o_ready=1 on the first cycle after reset.
- Operation:
  - op_add = ~(i_sign_a ^ i_sign_b).
  - Effective add: {ovf, res} = i_man_max + i_man_min, carry-in 0.
  - Effective subtract: res = i_man_max + ~i_man_min + cin, with cin = ~i_carry. ovf is forced to 0 and the carry-out is discarded.
  - The caller guarantees i_man_max ≥ i_man_min on subtract. If that is violated the result wraps mod 2^SIZE_MAN and no error is flagged.
- Pipeline:
  - Stage 1 (S1) registers the operands, op_add and cin.
  - Stage 2 (S2) registers res, ovf, zero and lzc, all computed from the S1 registers.
  - Latency is exactly 2 cycles from handshake accept (i_valid & o_ready at edge N) to o_valid at edge N+2, provided there is no backpressure.
- Handshake:
  - s2_load = s1_valid & (~s2_valid | i_ready).
  - s1_load = i_valid & o_ready.
  - o_ready = ~s1_valid | s2_load. This is combinational from i_ready, with no path from i_valid.
  - S1 holds its contents when s1_valid & ~s2_load.
  - S2 holds while o_valid & ~i_ready. All outputs must stay stable while held.
  - Full throughput is one op per cycle while i_ready=1.
  - Capacity is 2 ops. With i_ready=0, o_ready falls after two ops are accepted.
- Simultaneous events:
  - When S2 drains and S1 refills in the same cycle, both transfers occur and ordering is preserved.
  - When S1 is empty and S2 drains, s2_valid clears unless S1 had valid data.
- Invalid inputs: data ports are don't-care when i_valid=0. S1 data registers may still load but must not affect outputs.
- lzc/zero: computed on the SIZE_MAN-bit res only, ignoring ovf. The normaliser checks o_overflow first.
- No output is combinational from the data inputs. Everything is registered except o_ready.

Test Plan:
- SIZE_MAN=8, add: sign_a=0, sign_b=0, max=0xC0, min=0x50, carry=x, i_ready=1 -> 2 cycles later o_valid=1, o_man_alu=0x10, o_overflow=1, o_zero=0, o_lzc=3.
- Subtract, no borrow: sign_a=0, sign_b=1, max=0xC0, min=0x50, carry=0 -> o_man_alu=0x70, o_overflow=0, o_lzc=1.
- Subtract with borrow: same operands, carry=1 -> o_man_alu=0x6F, o_overflow=0, o_lzc=1.
- Exact cancel: sign_a=1, sign_b=0, max=min=0x80, carry=0 -> o_man_alu=0x00, o_zero=1, o_lzc=8.
- Backpressure and ordering:
  - Stimulus: four ops on consecutive cycles (0x01+0x01, 0x02+0x02, 0x03+0x03, 0x04+0x04), with i_ready=0 for cycles 0–5.
  - o_ready drops after 2 accepts and o_man_alu holds 0x02 stable.
  - After i_ready=1, results appear in order 0x02, 0x04, 0x06, 0x08, with no loss or duplication.
- Reset mid-operation: accept 2 ops, assert i_rst_n=0 asynchronously mid-cycle -> o_valid=0 and all outputs 0 immediately. After release, o_ready=1 and no stale result ever appears.
